pass_c: RTL and testbench



---
 rtl/pass_c_pkg.sv | 5 +
 rtl/pass_c_sync_fifo.sv | 58 +++++
 rtl/pass_c.sv | 60 ++++++
 tb/tb_pass_c.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/pass_c_pkg.sv
// Shared defaults for the pass_c write-side buffer.
package pass_c_pkg;
   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_DEPTH = 16;
endpackage

// File: rtl/pass_c_sync_fifo.sv
// Single-clock FIFO with power-of-two depth; a push while full is dropped unless a pop happens in the same cycle.
module sync_fifo
   import pass_c_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wr_data,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rd_data = mem[rd_ptr];

   // Storage carries no reset; only pointers and count are cleared.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/pass_c.sv
// Write-side buffer: bypasses straight to the output register when granted and empty, otherwise queues and drains in order.
module pass_c
   import pass_c_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             i_WrEn,
   input  logic [WIDTH-1:0] i_WrData,
   input  logic             i_Grant,
   output logic             o_Valid,
   output logic [WIDTH-1:0] o_Data,
   output logic             o_Grant
);
   localparam int AW = $clog2(DEPTH);

   logic             fifo_empty;
   logic             fifo_full;
   logic [AW:0]      fifo_count;
   logic [WIDTH-1:0] fifo_head;
   logic             fifo_push;
   logic             fifo_pop;
   logic             gnt;

   assign o_Grant = Reset & (i_WrEn | ~fifo_empty);
   assign gnt     = i_Grant & o_Grant;

   // A granted write into an empty FIFO skips storage; anything else queues behind existing words.
   assign fifo_pop  = gnt & ~fifo_empty;
   assign fifo_push = i_WrEn & ~(gnt & fifo_empty);

   sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (CLK),
      .rst_n   (Reset),
      .push    (fifo_push),
      .pop     (fifo_pop),
      .wr_data (i_WrData),
      .rd_data (fifo_head),
      .empty   (fifo_empty),
      .full    (fifo_full),
      .count   (fifo_count)
   );

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         o_Valid <= 1'b0;
         o_Data  <= '0;
      end else if (gnt) begin
         o_Valid <= 1'b1;
         o_Data  <= fifo_empty ? i_WrData : fifo_head;
      end else begin
         o_Valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_pass_c.sv
// Bench for pass_c: directed test-plan steps followed by random traffic, checked against a queue model.
module tb_pass_c;
   localparam int WIDTH = 8;
   localparam int DEPTH = 16;

   logic             clk;
   logic             rst_n;
   logic             wr_en;
   logic [WIDTH-1:0] wr_data;
   logic             own;
   logic             grant_in;
   logic             o_valid;
   logic [WIDTH-1:0] o_data;
   logic             o_grant;

   int checks;
   int failures;

   logic [WIDTH-1:0] q[$];
   logic             exp_valid;
   logic [WIDTH-1:0] exp_data;

   assign grant_in = own & o_grant;

   pass_c #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .CLK      (clk),
      .Reset    (rst_n),
      .i_WrEn   (wr_en),
      .i_WrData (wr_data),
      .i_Grant  (grant_in),
      .o_Valid  (o_valid),
      .o_Data   (o_data),
      .o_Grant  (o_grant)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One cycle: drive after the falling edge, check request, clock, then check outputs.
   task automatic step(input bit wr, input logic [WIDTH-1:0] d, input bit own_v);
      bit g;
      wr_en   = wr;
      wr_data = d;
      own     = own_v;
      #1;
      check("o_grant", 32'(o_grant), 32'(q.size() != 0 || wr));
      g = own_v && (q.size() != 0 || wr);
      @(posedge clk);
      if (wr && (q.size() < DEPTH || g)) q.push_back(d);
      if (g) begin
         exp_data  = q.pop_front();
         exp_valid = 1'b1;
      end else begin
         exp_valid = 1'b0;
      end
      #1;
      check("o_valid", 32'(o_valid), 32'(exp_valid));
      check("o_data", 32'(o_data), 32'(exp_data));
      check("count", 32'(dut.fifo_count), 32'(q.size()));
      @(negedge clk);
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      exp_valid = 1'b0;
      exp_data  = '0;
      rst_n     = 1'b0;
      wr_en     = 1'b0;
      wr_data   = '0;
      own       = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_valid", 32'(o_valid), 32'd0);
      check("rst_data", 32'(o_data), 32'd0);
      check("rst_grant", 32'(o_grant), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Bypass 1..4
      for (int i = 1; i <= 4; i++) step(1'b1, WIDTH'(i), 1'b1);
      step(1'b0, '0, 1'b1);

      // Queue 5..8 without grant, then hold idle
      for (int i = 5; i <= 8; i++) step(1'b1, WIDTH'(i), 1'b0);
      step(1'b0, '0, 1'b0);
      check("queued4", 32'(dut.fifo_count), 32'd4);

      // Drain while writing 9..12
      for (int i = 9; i <= 12; i++) step(1'b1, WIDTH'(i), 1'b1);
      for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);
      check("drained", 32'(dut.fifo_count), 32'd0);

      // Queue 13..16, drain 3, then write 17..20 as the last queued word pops
      for (int i = 13; i <= 16; i++) step(1'b1, WIDTH'(i), 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
      for (int i = 17; i <= 20; i++) step(1'b1, WIDTH'(i), 1'b1);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b1);

      // Overfill by two, then drain everything
      for (int i = 0; i < DEPTH + 2; i++) step(1'b1, WIDTH'(8'h40 + i), 1'b0);
      check("full_count", 32'(dut.fifo_count), 32'(DEPTH));
      for (int i = 0; i < DEPTH + 2; i++) step(1'b0, '0, 1'b1);

      // Full FIFO with simultaneous pop and push
      for (int i = 0; i < DEPTH; i++) step(1'b1, WIDTH'(8'h80 + i), 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, WIDTH'(8'hC0 + i), 1'b1);
      for (int i = 0; i < DEPTH + 1; i++) step(1'b0, '0, 1'b1);

      // Mid-operation reset with 3 queued and a write pending
      for (int i = 0; i < 3; i++) step(1'b1, WIDTH'(8'hE0 + i), 1'b0);
      step(1'b1, 8'h55, 1'b1);
      wr_en = 1'b1;
      own   = 1'b1;
      rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(o_valid), 32'd0);
      check("arst_data", 32'(o_data), 32'd0);
      check("arst_grant", 32'(o_grant), 32'd0);
      check("arst_count", 32'(dut.fifo_count), 32'd0);
      q.delete();
      exp_valid = 1'b0;
      exp_data  = '0;
      @(posedge clk);
      #1;
      check("arst_hold_valid", 32'(o_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      wr_en = 1'b0;
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
      step(1'b1, 8'hA5, 1'b1);
      step(1'b0, '0, 1'b1);

      // Random traffic in phases of differing grant bias
      for (int p = 0; p < 4; p++) begin
         for (int i = 0; i < 150; i++) begin
            bit w;
            bit o;
            w = ($urandom_range(0, 3) != 0);
            case (p)
               0:       o = ($urandom_range(0, 3) == 0);
               1:       o = ($urandom_range(0, 3) != 0);
               2:       o = ($urandom_range(0, 1) == 0);
               default: o = ($urandom_range(0, 7) != 0);
            endcase
            step(w, WIDTH'($urandom), o);
         end
      end
      for (int i = 0; i < DEPTH + 2; i++) step(1'b0, '0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
